alu_md_pipe: RTL and testbench
==============================

// Module: alu_md_pipe
// PURPOSE
//  Parametrised execute-stage ALU with an iterative multiply/divide (RV32M-style) unit.
//  Single-cycle ops return a registered result one cycle after issue. MUL*/DIV*/REM* ops run
//  on a shift-add / restoring-divide FSM and apply backpressure through in_ready.
//  Registered result and N/Z/C/V flags go to the following pipeline stage. flush kills in-flight work.
// PARAMETERS
//  XLEN   32  datapath width; must be a power of 2, >= 8
//  MD_EN  1   1: M-extension ops enabled; 0: M-extension encodings treated as illegal
// PORTS
//  clk        in   1     clock, rising edge
//  n_rst      in   1     asynchronous active-low reset
//  flush      in   1     synchronous kill, active high
//  in_valid   in   1     operands and op valid
//  in_ready   out  1     unit can accept an op this cycle
//  a_in       in   XLEN  operand A (rs1)
//  b_in       in   XLEN  operand B (rs2/imm)
//  alu_ctl    in   5     operation code, alu_pkg::alu_op_e
//  out_valid  out  1     result/flags valid this cycle, 1-cycle pulse
//  result     out  XLEN  registered result
//  aN,aZ,aC,aV out 1 each registered flags
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; result=0; aN/aZ/aC/aV=0.
//  Op codes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT, 00110 SLL,
//    00111 SRL, 01000 SRA, 01001 SLTU, 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU,
//    10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
//  Illegal op (any other code, or an M op with MD_EN=0): single-cycle; result=0; flags=0.
//  Accept = in_valid & in_ready. Single-cycle op: result/flags/out_valid registered on the
//    accepting edge. in_ready stays 1, so back-to-back issue runs at 1 op/cycle.
//  Adder: SUB/SLT/SLTU compute a+~b+1. C = carry out. V = signed overflow. N = sum[XLEN-1].
//    Z = (sum==0).
//  Flags: ADD/SUB/SLT/SLTU take the adder N,Z,C,V. AND/OR/XOR: N=msb, Z=(res==0), C=V=0.
//    All other ops: flags=0.
//  SLT: result = N^V, zero-extended. SLTU: result = ~C, zero-extended (unsigned a<b).
//  Shifts: amount = b_in[$clog2(XLEN)-1:0]. SRA replicates a_in[XLEN-1].
//  M ops: FSM IDLE -> BUSY -> DONE -> IDLE.
//    - Accept in IDLE loads the operands (absolute values for signed variants, sign fixes latched).
//      in_ready=0 from the next cycle.
//    - BUSY runs exactly XLEN iterations (counter 0..XLEN-1).
//    - DONE applies the sign fix, loads result, pulses out_valid and returns to IDLE with in_ready=1.
//    - Fixed latency: out_valid is high in the cycle XLEN+2 cycles after the accept cycle.
//  M flags are 0. MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits
//    of the 2*XLEN product.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a_in. Same fixed latency.
//  Signed overflow (DIV of -2^(XLEN-1) by -1): DIV -> -2^(XLEN-1); REM -> 0. Same latency.
//  flush: takes priority over everything. Next edge: state=IDLE, out_valid=0, result and
//    flags cleared to 0. An op offered in the same cycle is dropped. An M op in progress is
//    abandoned. in_ready=1 the cycle after the flush.
//  Reset asserted mid-operation: immediately returns to reset values. No partial result escapes.
//  out_valid is never high in two consecutive cycles for the same M op.
//  Between out_valid pulses, result/flags hold their last value.
// STRUCTURE
//  alu_pkg:
//    - alu_op_e enum (codes above)
//    - is_md_op() function
//    - XLEN_DEF=32
//    - md_state_e {IDLE,BUSY,DONE}
//  Sub-module md_unit:
//    - owns the FSM, iteration counter, accumulators and sign-fix logic
//    - drives busy, done and md_result
//  alu_md_pipe: adder, logic/shift ops, flag generation, op-select mux, output registers,
//    in_ready = ~busy.
// TESTING (XLEN=32)
//  1) ADD 0x7FFFFFFF + 1:
//     - result=0x80000000, aN=1, aV=1, aC=0, aZ=0
//     - out_valid exactly 1 cycle after accept
//  2) SLT/SLTU a=0xFFFFFFFF, b=1:
//     - SLT=1, SLTU=0
//     - SUB 5-5: result=0, aZ=1, aC=1
//  3) SRA 0x80000000 by 4 = 0xF8000000. SRL same = 0x08000000. b_in=0x25 shifts by 5.
//  4) MULH 0xFFFFFFFF*0xFFFFFFFF = 0x00000000. MULHU same = 0xFFFFFFFE:
//     - in_ready low for XLEN+1 cycles
//     - out_valid at cycle 34
//  5) Divide edge cases:
//     - DIV 7/0 = 0xFFFFFFFF; REM 7/0 = 7
//     - DIV 0x80000000/-1 = 0x80000000; REM = 0
//     - DIV -7/2 = -3; REM = -1
//  6) Flush handling:
//     - flush at iteration 10 of DIVU -> no out_valid, in_ready=1 next cycle
//     - a new ADD then completes normally
//     - n_rst pulsed mid-MUL -> all outputs 0

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM states, flag bundle and width defaults for the execute-stage ALU.
// Leaf package: no logic, no latency, no backpressure.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_AND    = 5'b00010,
        OP_OR     = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SLT    = 5'b00101,
        OP_SLL    = 5'b00110,
        OP_SRL    = 5'b00111,
        OP_SRA    = 5'b01000,
        OP_SLTU   = 5'b01001,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // All multiply/divide encodings live in 10xxx.
    function automatic logic is_md_op(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative shift-add multiplier / restoring divider; result presented XLEN+1 cycles after start.
// busy is high from the cycle after start until done; flush abandons the operation.
module md_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            flush,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    alu_op_e         op_q, op_d;
    logic            neg_q, neg_d;

    logic            a_sgn, b_sgn;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_rs;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [2*XLEN-1:0] prod_fix;

    assign a_sgn = a_in[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign b_sgn = b_in[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_rs   = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = div_rs >= {1'b0, opnd_q};
    assign div_diff = div_rs[XLEN-1:0] - opnd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = a_sgn ? -a_in : a_in;
                        opnd_d  = b_sgn ? -b_in : b_in;
                        op_d    = op;
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        if (op == OP_REM || op == OP_REMU)
                            neg_d = a_sgn;
                        else if (op == OP_DIV || op == OP_DIVU)
                            neg_d = (a_sgn ^ b_sgn) & (b_in != '0);
                        else
                            neg_d = a_sgn ^ b_sgn;
                    end
                end
                BUSY: begin
                    if (op_q[2]) begin
                        hi_d = div_ge ? div_diff : div_rs[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1))
                        state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    always_comb begin
        md_result = '0;
        case (op_q)
            OP_MUL:                        md_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  md_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               md_result = neg_q ? -lo_q : lo_q;
            OP_REM, OP_REMU:               md_result = neg_q ? -hi_q : hi_q;
            default:                       md_result = '0;
        endcase
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/alu_md_pipe.sv
// Execute-stage ALU: single-cycle ops register one cycle after issue, M ops XLEN+2 cycles.
// in_ready drops while the multiply/divide unit is busy; flush clears outputs and kills work.
module alu_md_pipe
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter bit MD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [4:0]      alu_ctl,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            aN,
    output logic            aZ,
    output logic            aC,
    output logic            aV
);

    localparam int SHW = $clog2(XLEN);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    flags_t          flags_q, flags_d;

    logic            accept, md_op, md_start, md_busy, md_done;
    logic [XLEN-1:0] md_result;
    logic            sub;
    logic [XLEN-1:0] b_op;
    logic [XLEN:0]   add_w;
    flags_t          add_flg;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] alu_res;
    flags_t          alu_flg;

    assign md_op    = MD_EN && is_md_op(alu_ctl);
    assign accept   = in_valid & in_ready;
    assign md_start = accept & md_op & ~flush;
    assign in_ready = ~md_busy;

    md_unit #(.XLEN(XLEN)) u_md (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .start     (md_start),
        .op        (alu_op_e'(alu_ctl)),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (md_busy),
        .done      (md_done),
        .md_result (md_result)
    );

    assign sub   = (alu_ctl == OP_SUB) || (alu_ctl == OP_SLT) || (alu_ctl == OP_SLTU);
    assign b_op  = sub ? ~b_in : b_in;
    assign add_w = {1'b0, a_in} + {1'b0, b_op} + {{XLEN{1'b0}}, sub};
    assign add_flg.n = add_w[XLEN-1];
    assign add_flg.z = add_w[XLEN-1:0] == '0;
    assign add_flg.c = add_w[XLEN];
    assign add_flg.v = (a_in[XLEN-1] == b_op[XLEN-1]) && (add_w[XLEN-1] != a_in[XLEN-1]);
    assign sh = b_in[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_flg = '0;
        case (alu_ctl)
            OP_ADD, OP_SUB: begin
                alu_res = add_w[XLEN-1:0];
                alu_flg = add_flg;
            end
            OP_SLT: begin
                alu_res = {{(XLEN-1){1'b0}}, add_flg.n ^ add_flg.v};
                alu_flg = add_flg;
            end
            OP_SLTU: begin
                alu_res = {{(XLEN-1){1'b0}}, ~add_flg.c};
                alu_flg = add_flg;
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (alu_ctl == OP_AND)
                    alu_res = a_in & b_in;
                else if (alu_ctl == OP_OR)
                    alu_res = a_in | b_in;
                else
                    alu_res = a_in ^ b_in;
                alu_flg.n = alu_res[XLEN-1];
                alu_flg.z = alu_res == '0;
            end
            OP_SLL:  alu_res = a_in << sh;
            OP_SRL:  alu_res = a_in >> sh;
            OP_SRA:  alu_res = $unsigned($signed(a_in) >>> sh);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        flags_d     = flags_q;
        if (flush) begin
            result_d = '0;
            flags_d  = '0;
        end else if (md_done) begin
            out_valid_d = 1'b1;
            result_d    = md_result;
            flags_d     = '0;
        end else if (accept && !md_op) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flags_d     = alu_flg;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign aN        = flags_q.n;
    assign aZ        = flags_q.z;
    assign aC        = flags_q.c;
    assign aV        = flags_q.v;

endmodule

// File: tb/tb_alu_md_pipe.sv
// Directed bench for alu_md_pipe: expected results are queued at issue and checked on out_valid.
module tb_alu_md_pipe;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [4:0]  alu_ctl = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        aN, aZ, aC, aV;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [3:0]  flg;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ncyc = 0;

    alu_md_pipe #(.XLEN(32), .MD_EN(1'b1)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .alu_ctl   (alu_ctl),
        .out_valid (out_valid),
        .result    (result),
        .aN        (aN),
        .aZ        (aZ),
        .aC        (aC),
        .aV        (aV)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every out_valid must match the oldest pending issue, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (n_rst && out_valid) begin
            n_cmp++;
            assert (sb.size() > 0)
            else begin
                n_fail++;
                $error("FAIL unexpected_out_valid got result %h with no pending op", result);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                assert (result === e.res)
                else begin
                    n_fail++;
                    $error("FAIL %s result got %h exp %h", e.tag, result, e.res);
                end
                n_cmp++;
                assert ({aN, aZ, aC, aV} === e.flg)
                else begin
                    n_fail++;
                    $error("FAIL %s flags NZCV got %b exp %b", e.tag, {aN, aZ, aC, aV}, e.flg);
                end
                n_cmp++;
                assert (ncyc == e.due)
                else begin
                    n_fail++;
                    $error("FAIL %s latency out_valid cycle got %0d exp %0d", e.tag, ncyc, e.due);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready, offers one op for one cycle, optionally queues its expectation.
    task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit track, input logic [31:0] er,
                         input logic [3:0] ef, input int lat);
        int w;
        exp_t e;
        @(negedge clk);
        #1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s in_ready timeout got 0 exp 1", tag);
        end
        alu_ctl  = op;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        if (track) begin
            e.tag = tag;
            e.res = er;
            e.flg = ef;
            e.due = ncyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int lo_cnt;
        int w;

        #12;
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {28'h0, aN, aZ, aC, aV}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        n_rst = 1'b1;

        // Single-cycle ops, back to back.
        issue("add_ovf", 5'b00000, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 4'b1001, 1);
        issue("slt",     5'b00101, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000001, 4'b1010, 1);
        issue("sltu",    5'b01001, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 4'b1010, 1);
        issue("sub_zero",5'b00001, 32'h00000005, 32'h00000005, 1, 32'h00000000, 4'b0110, 1);
        issue("and",     5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 4'b1000, 1);
        issue("or_zero", 5'b00011, 32'h00000000, 32'h00000000, 1, 32'h00000000, 4'b0100, 1);
        issue("xor",     5'b00100, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 4'b1000, 1);
        issue("sra",     5'b01000, 32'h80000000, 32'h00000004, 1, 32'hF8000000, 4'b0000, 1);
        issue("srl",     5'b00111, 32'h80000000, 32'h00000004, 1, 32'h08000000, 4'b0000, 1);
        issue("srl_mask",5'b00111, 32'h80000000, 32'h00000025, 1, 32'h04000000, 4'b0000, 1);
        issue("sll_mask",5'b00110, 32'h00000001, 32'h00000025, 1, 32'h00000020, 4'b0000, 1);
        issue("illegal", 5'b01111, 32'h00000001, 32'h00000001, 1, 32'h00000000, 4'b0000, 1);

        // Multiply; also count the in_ready-low window of one op.
        issue("mulh",    5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 4'b0000, 34);
        issue("mulhu",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 4'b0000, 34);
        lo_cnt = 0;
        w = 0;
        @(negedge clk);
        #1;
        while (!in_ready && w < 100) begin
            lo_cnt++;
            w++;
            @(negedge clk);
            #1;
        end
        chk("mulhu_ready_low_cycles", lo_cnt, 32'd33);
        issue("mul",     5'b10000, 32'hFFFFFFFD, 32'h00000005, 1, 32'hFFFFFFF1, 4'b0000, 34);
        issue("mulhsu",  5'b10010, 32'hFFFFFFFF, 32'h00000002, 1, 32'hFFFFFFFF, 4'b0000, 34);

        // Divide, including zero divisor and signed overflow.
        issue("div_by0", 5'b10100, 32'h00000007, 32'h00000000, 1, 32'hFFFFFFFF, 4'b0000, 34);
        issue("rem_by0", 5'b10110, 32'h00000007, 32'h00000000, 1, 32'h00000007, 4'b0000, 34);
        issue("divn_by0",5'b10100, 32'hFFFFFFF9, 32'h00000000, 1, 32'hFFFFFFFF, 4'b0000, 34);
        issue("remn_by0",5'b10110, 32'hFFFFFFF9, 32'h00000000, 1, 32'hFFFFFFF9, 4'b0000, 34);
        issue("div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 4'b0000, 34);
        issue("rem_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 4'b0000, 34);
        issue("div_neg", 5'b10100, 32'hFFFFFFF9, 32'h00000002, 1, 32'hFFFFFFFD, 4'b0000, 34);
        issue("rem_neg", 5'b10110, 32'hFFFFFFF9, 32'h00000002, 1, 32'hFFFFFFFF, 4'b0000, 34);
        issue("divu",    5'b10101, 32'h00000064, 32'h00000007, 1, 32'h0000000E, 4'b0000, 34);
        issue("remu",    5'b10111, 32'h00000064, 32'h00000007, 1, 32'h00000002, 4'b0000, 34);

        // Flush during iteration 10 of a DIVU, with an ADD offered alongside.
        issue("divu_killed", 5'b10101, 32'h00001000, 32'h00000003, 0, 32'h0, 4'b0, 0);
        repeat (11) @(negedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_ctl  = 5'b00000;
        a_in     = 32'h00000001;
        b_in     = 32'h00000001;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_result", result, 32'h0);
        chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
        issue("add_after_flush", 5'b00000, 32'h0000000A, 32'h00000014, 1, 32'h0000001E, 4'b0000, 1);

        // Flush in idle drops the op offered with it and clears the held result.
        @(negedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_ctl  = 5'b00000;
        a_in     = 32'h00000003;
        b_in     = 32'h00000004;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_idle_out_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_idle_result", result, 32'h0);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of a MUL.
        issue("add_pre_rst", 5'b00000, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 4'b1001, 1);
        issue("mul_killed",  5'b10000, 32'h00000003, 32'h00000005, 0, 32'h0, 4'b0, 0);
        repeat (5) @(negedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_result", result, 32'h0);
        chk("rst_mid_flags", {28'h0, aN, aZ, aC, aV}, 32'h0);
        chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        repeat (40) @(negedge clk);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
